// File: rtl/tcpc_pkg.sv
// tcpc_pkg: definitions shared by the TCPC register arbiter and its round-robin
// sub-arbiter.
//   tcpc_state_t     : arbiter FSM states (IDLE, ISSUE, DONE)
//   REQ_H / REQ_E    : requester IDs (host I2C slave / PD protocol engine)
//   RO_LIMIT_DEFAULT : first writable address for the host
//   TIMEOUT_DEFAULT  : ISSUE cycles without a bank ACK before aborting
//   TIMEOUT_RD_DATA  : read data returned for a read that timed out
package tcpc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } tcpc_state_t;

    localparam logic       REQ_H            = 1'b0;
    localparam logic       REQ_E            = 1'b1;
    localparam logic [7:0] RO_LIMIT_DEFAULT = 8'h10;
    localparam int         TIMEOUT_DEFAULT  = 16;
    localparam logic [7:0] TIMEOUT_RD_DATA  = 8'hFF;

endpackage

// File: rtl/tcpc_rr_arb2.sv
// tcpc_rr_arb2: two-input round-robin arbiter with a last-grant pointer.
//   clk, reset_n  : clock, asynchronous active-low reset
//   req_h, req_e  : request from host / engine
//   grant_en      : the pointer follows the winner only when this is high
//   grant_valid   : at least one request is pending (combinational)
//   grant_id      : winning requester ID (combinational)
// On a tie the requester that was not granted last wins. The pointer resets to
// REQ_E so the first tie after reset goes to the host.
module tcpc_rr_arb2
    import tcpc_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_h,
    input  logic req_e,
    input  logic grant_en,
    output logic grant_valid,
    output logic grant_id
);

    logic last_id;

    always_comb begin
        grant_valid = req_h | req_e;
        grant_id    = REQ_H;
        if (req_h && req_e) begin
            grant_id = (last_id == REQ_H) ? REQ_E : REQ_H;
        end else if (req_e) begin
            grant_id = REQ_E;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_id <= REQ_E;
        end else if (grant_en && grant_valid) begin
            last_id <= grant_id;
        end
    end

endmodule

// File: rtl/tcpc_reg_arbiter.sv
// tcpc_reg_arbiter: shares the single-port TCPC register bank between the host
// I2C slave (h_*) and the PD protocol engine (e_*).
//   clk, reset_n                     : clock, asynchronous active-low reset
//   h_/e_req, _addr, _rnw, _wr_data  : requester transaction inputs
//   h_/e_rd_data, _ack, _err         : requester completion outputs
//   bank_req, bank_addr, bank_rnw,
//   bank_wr_data                     : request to the register bank
//   bank_rd_data, bank_ack           : bank completion
//   busy                             : state is not IDLE
//   state_dbg                        : current FSM state
//
// Handshake: a requester raises req with addr/rnw/wr_data stable and holds it
// until it sees a one-cycle ack; err qualifies that ack (1 = rejected RO write
// or bank timeout) and rd_data is valid only in the ack cycle. Towards the
// bank, bank_req stays high with a stable command until bank_ack is sampled or
// the timeout expires; bank_ack outside ISSUE is ignored.
module tcpc_reg_arbiter
    import tcpc_pkg::*;
#(
    parameter int         TIMEOUT  = TIMEOUT_DEFAULT,
    parameter logic [7:0] RO_LIMIT = RO_LIMIT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        h_req,
    input  logic [7:0]  h_addr,
    input  logic        h_rnw,
    input  logic [7:0]  h_wr_data,
    output logic [7:0]  h_rd_data,
    output logic        h_ack,
    output logic        h_err,
    input  logic        e_req,
    input  logic [7:0]  e_addr,
    input  logic        e_rnw,
    input  logic [7:0]  e_wr_data,
    output logic [7:0]  e_rd_data,
    output logic        e_ack,
    output logic        e_err,
    output logic        bank_req,
    output logic [7:0]  bank_addr,
    output logic        bank_rnw,
    output logic [7:0]  bank_wr_data,
    input  logic [7:0]  bank_rd_data,
    input  logic        bank_ack,
    output logic        busy,
    output tcpc_state_t state_dbg
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    tcpc_state_t state;
    logic        gnt_id;
    logic [7:0]  tmo_cnt;

    logic        grant_valid;
    logic        grant_id;
    logic [7:0]  sel_addr;
    logic        sel_rnw;
    logic [7:0]  sel_wr_data;
    logic        sel_reject;

    logic        issue_exit;
    logic        issue_err;
    logic [7:0]  issue_rd;

    tcpc_rr_arb2 u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_h       (h_req),
        .req_e       (e_req),
        .grant_en    (state == IDLE),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_addr    = (grant_id == REQ_H) ? h_addr    : e_addr;
        sel_rnw     = (grant_id == REQ_H) ? h_rnw     : e_rnw;
        sel_wr_data = (grant_id == REQ_H) ? h_wr_data : e_wr_data;
        // Only the host is fenced off the ID/capability region.
        sel_reject  = (grant_id == REQ_H) && !sel_rnw && (sel_addr < RO_LIMIT);
    end

    // How ISSUE ends: bank ACK wins over an expiring timeout in the same cycle.
    always_comb begin
        issue_exit = 1'b0;
        issue_err  = 1'b0;
        issue_rd   = 8'h00;
        if (state == ISSUE) begin
            if (bank_ack) begin
                issue_exit = 1'b1;
                issue_rd   = bank_rnw ? bank_rd_data : 8'h00;
            end else if (tmo_cnt == TMO_LAST) begin
                issue_exit = 1'b1;
                issue_err  = 1'b1;
                issue_rd   = bank_rnw ? TIMEOUT_RD_DATA : 8'h00;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            gnt_id       <= REQ_H;
            tmo_cnt      <= 8'd0;
            bank_req     <= 1'b0;
            bank_addr    <= 8'h00;
            bank_rnw     <= 1'b1;
            bank_wr_data <= 8'h00;
            busy         <= 1'b0;
            h_ack        <= 1'b0;
            h_err        <= 1'b0;
            h_rd_data    <= 8'h00;
            e_ack        <= 1'b0;
            e_err        <= 1'b0;
            e_rd_data    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gnt_id  <= grant_id;
                        busy    <= 1'b1;
                        tmo_cnt <= 8'd0;
                        if (sel_reject) begin
                            // Rejected without touching the bank.
                            state     <= DONE;
                            h_ack     <= 1'b1;
                            h_err     <= 1'b1;
                            h_rd_data <= 8'h00;
                        end else begin
                            state        <= ISSUE;
                            bank_req     <= 1'b1;
                            bank_addr    <= sel_addr;
                            bank_rnw     <= sel_rnw;
                            bank_wr_data <= sel_wr_data;
                        end
                    end
                end
                ISSUE: begin
                    if (issue_exit) begin
                        state    <= DONE;
                        bank_req <= 1'b0;
                        if (gnt_id == REQ_H) begin
                            h_ack     <= 1'b1;
                            h_err     <= issue_err;
                            h_rd_data <= issue_rd;
                        end else begin
                            e_ack     <= 1'b1;
                            e_err     <= issue_err;
                            e_rd_data <= issue_rd;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    h_ack     <= 1'b0;
                    h_err     <= 1'b0;
                    h_rd_data <= 8'h00;
                    e_ack     <= 1'b0;
                    e_err     <= 1'b0;
                    e_rd_data <= 8'h00;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_tcpc_reg_arbiter.sv
// tb_tcpc_reg_arbiter: table of single transactions plus hand-written sequences
// for timeout, back-to-back arbitration and reset during ISSUE. Completions are
// checked by a scoreboard fed from the drivers.
module tb_tcpc_reg_arbiter;
    import tcpc_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        h_req, e_req;
    logic [7:0]  h_addr, e_addr;
    logic        h_rnw, e_rnw;
    logic [7:0]  h_wr_data, e_wr_data;
    logic [7:0]  h_rd_data, e_rd_data;
    logic        h_ack, e_ack, h_err, e_err;
    logic        bank_req, bank_rnw, bank_ack;
    logic [7:0]  bank_addr, bank_wr_data, bank_rd_data;
    logic        busy;
    tcpc_state_t state_dbg;

    tcpc_reg_arbiter #(.TIMEOUT(16), .RO_LIMIT(8'h10)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .h_req        (h_req),
        .h_addr       (h_addr),
        .h_rnw        (h_rnw),
        .h_wr_data    (h_wr_data),
        .h_rd_data    (h_rd_data),
        .h_ack        (h_ack),
        .h_err        (h_err),
        .e_req        (e_req),
        .e_addr       (e_addr),
        .e_rnw        (e_rnw),
        .e_wr_data    (e_wr_data),
        .e_rd_data    (e_rd_data),
        .e_ack        (e_ack),
        .e_err        (e_err),
        .bank_req     (bank_req),
        .bank_addr    (bank_addr),
        .bank_rnw     (bank_rnw),
        .bank_wr_data (bank_wr_data),
        .bank_rd_data (bank_rd_data),
        .bank_ack     (bank_ack),
        .busy         (busy),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at 500000, required finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- bank model ----------------
    logic [7:0] mem [256];
    int         bank_wait = 0;
    bit         bank_never = 0;
    int         wcnt = 0;
    int         bank_req_cycles = 0;
    logic [7:0] last_wr_addr = 8'h00;
    logic [7:0] last_wr_data = 8'h00;

    always @(negedge clk) begin
        if (bank_req) bank_req_cycles++;
        if (bank_req && !bank_never && !bank_ack) begin
            if (wcnt >= bank_wait) begin
                bank_ack     = 1'b1;
                bank_rd_data = mem[bank_addr];
                if (!bank_rnw) begin
                    mem[bank_addr] = bank_wr_data;
                    last_wr_addr   = bank_addr;
                    last_wr_data   = bank_wr_data;
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            bank_ack     = 1'b0;
            bank_rd_data = 8'h00;
            if (!bank_req) wcnt = 0;
        end
    end

    // ---------------- scoreboard ----------------
    logic [9:0] exp_q[$];
    logic [9:0] got_w, exp_w;

    always @(negedge clk) begin
        if (h_ack || e_ack) begin
            if (h_ack && e_ack) begin
                checks++;
                errors++;
                $display("FAIL both_ack: got h_ack=1 e_ack=1, required only one");
            end
            got_w = h_ack ? {REQ_H, h_err, h_rd_data} : {REQ_E, e_err, e_rd_data};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack: got {id,err,rd}=%03h, required no ack", got_w);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    errors++;
                    $display("FAIL ack_payload: got {id,err,rd}=%03h, required %03h", got_w, exp_w);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_bank_req"},     32'(bank_req),     32'h0);
        chk({tag, "_bank_addr"},    32'(bank_addr),    32'h0);
        chk({tag, "_bank_wr_data"}, 32'(bank_wr_data), 32'h0);
        chk({tag, "_bank_rnw"},     32'(bank_rnw),     32'h1);
        chk({tag, "_acks"},         32'({h_ack, e_ack}), 32'h0);
        chk({tag, "_errs"},         32'({h_err, e_err}), 32'h0);
        chk({tag, "_rd_data"},      32'({h_rd_data, e_rd_data}), 32'h0);
        chk({tag, "_busy"},         32'(busy),         32'h0);
        chk({tag, "_state"},        32'(state_dbg),    32'(IDLE));
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ack(input logic id, input int max_cyc, output int lat);
        bit seen;
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < max_cyc) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            seen = (id == REQ_H) ? h_ack : e_ack;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no ack for id %0d, required one within %0d cycles", id, max_cyc);
        end
    endtask

    typedef struct {
        logic       id;
        logic       rnw;
        logic [7:0] addr;
        logic [7:0] wd;
        int         waits;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         exp_lat;
        int         exp_bank_cyc;
    } vec_t;

    // Called at a falling edge with the DUT in IDLE; returns the same way.
    task automatic run_txn(input int idx, input vec_t v);
        int lat;
        int cyc0;
        bank_wait = v.waits;
        cyc0 = bank_req_cycles;
        exp_q.push_back({v.id, v.exp_err, v.exp_rd});
        if (v.id == REQ_H) begin
            h_req = 1'b1; h_rnw = v.rnw; h_addr = v.addr; h_wr_data = v.wd;
        end else begin
            e_req = 1'b1; e_rnw = v.rnw; e_addr = v.addr; e_wr_data = v.wd;
        end
        wait_ack(v.id, 40, lat);
        h_req = 1'b0;
        e_req = 1'b0;
        chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
        chk($sformatf("v%0d_bank_req_cycles", idx), 32'(bank_req_cycles - cyc0), 32'(v.exp_bank_cyc));
        if (!v.rnw && !v.exp_err)
            chk($sformatf("v%0d_bank_write", idx), 32'({last_wr_addr, last_wr_data}), 32'({v.addr, v.wd}));
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- test ----------------
    vec_t vecs[13];
    vec_t tv;
    int   lat;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h29;
        mem[8'h05] = 8'hA5;
        mem[8'h0F] = 8'h77;

        //          id     rnw   addr   wd     w  err   rd     lat cyc
        vecs[0]  = '{REQ_H, 1'b1, 8'h00, 8'h00, 0, 1'b0, 8'h29, 2, 1};
        vecs[1]  = '{REQ_H, 1'b0, 8'h02, 8'h05, 0, 1'b1, 8'h00, 1, 0};
        vecs[2]  = '{REQ_E, 1'b0, 8'h02, 8'h05, 0, 1'b0, 8'h00, 2, 1};
        vecs[3]  = '{REQ_E, 1'b1, 8'h02, 8'h00, 1, 1'b0, 8'h05, 3, 2};
        vecs[4]  = '{REQ_H, 1'b0, 8'h30, 8'hC3, 2, 1'b0, 8'h00, 4, 3};
        vecs[5]  = '{REQ_H, 1'b1, 8'h30, 8'h00, 0, 1'b0, 8'hC3, 2, 1};
        vecs[6]  = '{REQ_H, 1'b0, 8'h0F, 8'h11, 0, 1'b1, 8'h00, 1, 0};
        vecs[7]  = '{REQ_E, 1'b1, 8'h0F, 8'h00, 0, 1'b0, 8'h77, 2, 1};
        vecs[8]  = '{REQ_H, 1'b0, 8'h10, 8'h3C, 0, 1'b0, 8'h00, 2, 1};
        vecs[9]  = '{REQ_E, 1'b1, 8'h10, 8'h00, 3, 1'b0, 8'h3C, 5, 4};
        vecs[10] = '{REQ_H, 1'b1, 8'h05, 8'h00, 0, 1'b0, 8'hA5, 2, 1};
        vecs[11] = '{REQ_E, 1'b0, 8'h01, 8'hE1, 0, 1'b0, 8'h00, 2, 1};
        vecs[12] = '{REQ_H, 1'b1, 8'h01, 8'h00, 0, 1'b0, 8'hE1, 2, 1};

        h_req = 0; h_addr = 0; h_rnw = 0; h_wr_data = 0;
        e_req = 0; e_addr = 0; e_rnw = 0; e_wr_data = 0;
        bank_ack = 0; bank_rd_data = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) run_txn(i, vecs[i]);

        // Bank that never answers, then a normal transaction.
        bank_never = 1'b1;
        tv = '{REQ_H, 1'b1, 8'h40, 8'h00, 0, 1'b1, 8'hFF, 17, 16};
        run_txn(20, tv);
        bank_never = 1'b0;
        tv = '{REQ_E, 1'b1, 8'h00, 8'h00, 0, 1'b0, 8'h29, 2, 1};
        run_txn(21, tv);

        // E write to 0x10 is in flight when H asks to read it back.
        bank_wait = 0;
        e_req = 1'b1; e_rnw = 1'b0; e_addr = 8'h10; e_wr_data = 8'h5D;
        exp_q.push_back({REQ_E, 1'b0, 8'h00});
        @(posedge clk);
        @(negedge clk);
        chk("ealert_state_issue", 32'(state_dbg), 32'(ISSUE));
        h_req = 1'b1; h_rnw = 1'b1; h_addr = 8'h10;
        exp_q.push_back({REQ_H, 1'b0, 8'h5D});
        wait_ack(REQ_E, 10, lat);
        e_req = 1'b0;
        chk("ealert_e_latency", 32'(lat), 32'd1);
        wait_ack(REQ_H, 10, lat);
        h_req = 1'b0;
        chk("ealert_h_after_e", 32'(lat), 32'd3);
        @(posedge clk);
        @(negedge clk);

        // Reset during ISSUE with a slow bank: no ack may follow.
        bank_wait = 3;
        h_req = 1'b1; h_rnw = 1'b1; h_addr = 8'h00;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("midrst_state_issue", 32'(state_dbg), 32'(ISSUE));
        chk("midrst_bank_req", 32'(bank_req), 32'h1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        h_req = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // First tie after reset: H, E, H, E, each back-to-back.
        bank_wait = 0;
        h_req = 1'b1; h_rnw = 1'b1; h_addr = 8'h00;
        e_req = 1'b1; e_rnw = 1'b1; e_addr = 8'h30;
        exp_q.push_back({REQ_H, 1'b0, 8'h29});
        exp_q.push_back({REQ_E, 1'b0, 8'hC3});
        exp_q.push_back({REQ_H, 1'b0, 8'h29});
        exp_q.push_back({REQ_E, 1'b0, 8'hC3});
        wait_ack(REQ_H, 10, lat);
        chk("tie1_h_latency", 32'(lat), 32'd2);
        wait_ack(REQ_E, 10, lat);
        chk("tie2_e_latency", 32'(lat), 32'd3);
        wait_ack(REQ_H, 10, lat);
        h_req = 1'b0;
        chk("tie3_h_latency", 32'(lat), 32'd3);
        wait_ack(REQ_E, 10, lat);
        e_req = 1'b0;
        chk("tie4_e_latency", 32'(lat), 32'd3);
        repeat (3) @(negedge clk);
        chk("final_idle", 32'(state_dbg), 32'(IDLE));
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
